// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the shift_serializer block.
//   DATA_W  : default data width of a transmitted word
//   state_t : FSM state encoding (IDLE, SHIFT, PAR, GAP)
//   max_int : elaboration-time helper for sizing counters
package shift_serializer_pkg;

  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/shift_serializer_bit_counter.sv
// Loadable down-counter shared by the serializer for the bit count and the
// inter-word gap count. Decrement saturates at zero, so the count never wraps.
// Ports:
//   clk    : system clock, rising edge
//   rst    : synchronous reset, active-high (count -> 0)
//   ld     : load ld_val (has priority over dec)
//   ld_val : value to load
//   dec    : decrement by one when nonzero
//   cnt    : current count
//   zero   : cnt == 0 (terminal count)
module shift_serializer_bit_counter #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter that loads a shift register through its
// serial input. A WIDTH-bit word is taken over valid/ready and sent one bit
// per cycle alongside a shift strobe; sh_last marks the final strobe.
//
// Optional feature: define SER_PARITY_EN to append an even-parity strobe
// after the data bits (sh_last then moves to the parity strobe).
//
// Parameters:
//   WIDTH     : data bits per word (>= 2)
//   LSB_FIRST : 1 = bit0 first (drive sr/ir), 0 = bit WIDTH-1 first (sl/il)
//   GAP       : idle cycles after each frame before in_ready rises (0..15)
// Ports:
//   clk      : system clock, rising edge
//   rst      : synchronous reset, active-high
//   in_valid : in_data is valid
//   in_data  : word to transmit
//   in_ready : block accepts a word this cycle (IDLE only)
//   sh_en    : shift strobe for the attached register
//   sh_bit   : serial bit, 0 whenever sh_en is low
//   sh_last  : high with sh_en on the final strobe of a frame
//   busy     : high in every state except IDLE
//
// state  | meaning
// IDLE   | waiting for a word, in_ready high
// SHIFT  | emitting data bits, one strobe per cycle
// PAR    | emitting the parity strobe (SER_PARITY_EN only)
// GAP    | enforced idle time after a frame
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter bit LSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sh_en,
  output logic             sh_bit,
  output logic             sh_last,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  // One counter serves both the bit count and the gap count, so it is sized
  // for whichever needs more bits.
  localparam int CW = max_int(max_int($clog2(WIDTH), $clog2(GAP + 1)), 1);
  localparam logic [CW-1:0] BIT_LD = CW'(WIDTH - 1);
  localparam logic [CW-1:0] GAP_LD = CW'((GAP > 0) ? (GAP - 1) : 0);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;

  logic             accept;
  logic             frame_done;
  logic             cnt_ld;
  logic             cnt_dec;
  logic             cnt_zero;
  logic [CW-1:0]    cnt_ld_val;
  logic [CW-1:0]    cnt;

  logic             first_bit;
  logic             next_bit;
  logic [WIDTH-1:0] shreg_shifted;

  // in_ready is high exactly in IDLE, so the handshake reduces to this.
  assign accept     = (state == ST_IDLE) && in_valid;
  assign frame_done = ((state == ST_SHIFT) && cnt_zero && !PAR_EN) ||
                      (state == ST_PAR);

  assign cnt_ld     = accept || (frame_done && (GAP > 0));
  assign cnt_ld_val = accept ? BIT_LD : GAP_LD;
  assign cnt_dec    = (state == ST_SHIFT) || (state == ST_GAP);

  assign first_bit     = LSB_FIRST ? in_data[0] : in_data[WIDTH-1];
  assign next_bit      = LSB_FIRST ? shreg[1]   : shreg[WIDTH-2];
  assign shreg_shifted = LSB_FIRST ? {1'b0, shreg[WIDTH-1:1]}
                                   : {shreg[WIDTH-2:0], 1'b0};

  shift_serializer_bit_counter #(
    .CW(CW)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .ld     (cnt_ld),
    .ld_val (cnt_ld_val),
    .dec    (cnt_dec),
    .cnt    (cnt),
    .zero   (cnt_zero)
  );

  // Outputs are registered: each branch sets the values the next state shows.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      par_bit  <= 1'b0;
      in_ready <= 1'b1;
      sh_en    <= 1'b0;
      sh_bit   <= 1'b0;
      sh_last  <= 1'b0;
      busy     <= 1'b0;
    end else if (frame_done) begin
      sh_en   <= 1'b0;
      sh_bit  <= 1'b0;
      sh_last <= 1'b0;
      if (GAP > 0) begin
        state <= ST_GAP;
      end else begin
        state    <= ST_IDLE;
        in_ready <= 1'b1;
        busy     <= 1'b0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_SHIFT;
            shreg    <= in_data;
            par_bit  <= ^in_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            sh_en    <= 1'b1;
            sh_bit   <= first_bit;
            sh_last  <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (!cnt_zero) begin
            shreg   <= shreg_shifted;
            sh_bit  <= next_bit;
            // the strobe shown with cnt==0 is the last data bit
            sh_last <= (cnt == ONE) && !PAR_EN;
          end else begin
            state   <= ST_PAR;
            sh_bit  <= par_bit;
            sh_last <= 1'b1;
          end
        end
        ST_GAP: begin
          if (cnt_zero) begin
            state    <= ST_IDLE;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Bench for shift_serializer. Three instances: LSB-first/no gap,
// MSB-first/no gap, LSB-first/gap of 3. Stimulus pushes hand-computed frames
// into per-instance queues; a negedge monitor pops and checks every strobe,
// the handshake/busy levels, and a model of the downstream 4-bit register.
module tb_shift_serializer;

  localparam int         N_DUT   = 3;
  localparam logic [2:0] LSB_CFG = 3'b101;
  localparam int         GAP2    = 3;
`ifdef SER_PARITY_EN
  localparam int FL = 5;
`else
  localparam int FL = 4;
`endif

  typedef struct packed {
    logic [3:0] word;
    logic [4:0] bits;   // transmit order, first bit at index FL-1
    int         start;  // cycle of the first strobe
  } entry_t;

  logic       clk = 1'b0;
  logic       rst_a      [N_DUT];
  logic       in_valid_a [N_DUT];
  logic [3:0] in_data_a  [N_DUT];
  logic       in_ready_a [N_DUT];
  logic       sh_en_a    [N_DUT];
  logic       sh_bit_a   [N_DUT];
  logic       sh_last_a  [N_DUT];
  logic       busy_a     [N_DUT];

  entry_t sbq [N_DUT][$];
  int     cyc     = 0;
  bit     started = 1'b0;
  bit     done    = 1'b0;
  int     checks  = 0;
  int     errors  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    shift_serializer #(
      .WIDTH     (4),
      .LSB_FIRST (LSB_CFG[g]),
      .GAP       ((g == 2) ? GAP2 : 0)
    ) dut (
      .clk      (clk),
      .rst      (rst_a[g]),
      .in_valid (in_valid_a[g]),
      .in_data  (in_data_a[g]),
      .in_ready (in_ready_a[g]),
      .sh_en    (sh_en_a[g]),
      .sh_bit   (sh_bit_a[g]),
      .sh_last  (sh_last_a[g]),
      .busy     (busy_a[g])
    );
  end

  function automatic int gap_of(input int d);
    return (d == 2) ? GAP2 : 0;
  endfunction

  function automatic entry_t mk(input logic [3:0] w, input logic [3:0] seq,
                                input logic p, input int s);
    entry_t e;
    e.word  = w;
    e.bits  = (FL == 5) ? {seq, p} : {1'b0, seq};
    e.start = s;
    return e;
  endfunction

  task automatic check_bit(input int d, input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL dut%0d %s actual=%b required=%b cycle=%0d", d, name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input int d, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL dut%0d %s actual=%0d required=%0d cycle=%0d", d, name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         idx      [N_DUT];
  int         gap_left [N_DUT];
  bit         cur_ok   [N_DUT];
  entry_t     cur      [N_DUT];
  logic [3:0] reg_m    [N_DUT];

  initial begin
    for (int d = 0; d < N_DUT; d++) begin
      idx[d] = 0; gap_left[d] = 0; cur_ok[d] = 1'b0; reg_m[d] = 4'h0;
    end
  end

  always @(negedge clk) begin
    logic [3:0] exp_reg;
    logic       par;
    if (started) begin
      for (int d = 0; d < N_DUT; d++) begin
        if (sh_en_a[d]) begin
          if (idx[d] == 0) begin
            cur_ok[d] = (sbq[d].size() != 0);
            check_bit(d, "frame_expected", cur_ok[d], 1'b1);
            if (cur_ok[d]) begin
              cur[d] = sbq[d].pop_front();
              check_int(d, "first_strobe_cycle", cyc, cur[d].start);
            end
          end
          check_bit(d, "in_ready_in_frame", in_ready_a[d], 1'b0);
          check_bit(d, "busy_in_frame", busy_a[d], 1'b1);
          if (cur_ok[d]) begin
            check_bit(d, "sh_bit", sh_bit_a[d], cur[d].bits[FL-1-idx[d]]);
            check_bit(d, "sh_last", sh_last_a[d], (idx[d] == FL - 1));
          end
          reg_m[d] = LSB_CFG[d] ? {sh_bit_a[d], reg_m[d][3:1]} : {reg_m[d][2:0], sh_bit_a[d]};
          idx[d]++;
          if (sh_last_a[d] || idx[d] >= FL) begin
            if (cur_ok[d] && idx[d] == FL) begin
              par = ^cur[d].word;
              if (FL == 5)
                exp_reg = LSB_CFG[d] ? {par, cur[d].word[3:1]} : {cur[d].word[2:0], par};
              else
                exp_reg = cur[d].word;
              check_int(d, "register_out", int'(reg_m[d]), int'(exp_reg));
            end
            idx[d]      = 0;
            gap_left[d] = gap_of(d);
            cur_ok[d]   = 1'b0;
          end
        end else begin
          check_bit(d, "sh_bit_idle", sh_bit_a[d], 1'b0);
          check_bit(d, "sh_last_idle", sh_last_a[d], 1'b0);
          check_int(d, "frame_contiguous", idx[d], 0);
          idx[d] = 0;
          if (gap_left[d] > 0) begin
            check_bit(d, "in_ready_gap", in_ready_a[d], 1'b0);
            check_bit(d, "busy_gap", busy_a[d], 1'b1);
            gap_left[d]--;
          end else begin
            check_bit(d, "in_ready_idle", in_ready_a[d], 1'b1);
            check_bit(d, "busy_idle", busy_a[d], 1'b0);
          end
        end
        if (rst_a[d]) begin
          idx[d] = 0; gap_left[d] = 0; cur_ok[d] = 1'b0;
        end
      end
      if (done) begin
        for (int d = 0; d < N_DUT; d++)
          check_int(d, "queue_drained", sbq[d].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  // Called at #1 after a rising edge. Waits (bounded) for in_ready, pushes
  // the expected frame, and returns #1 after the accept edge.
  task automatic send(input int d, input logic [3:0] w, input logic [3:0] seq,
                      input logic p, input bit hold, output int s);
    s = -1;
    in_valid_a[d] = 1'b1;
    in_data_a[d]  = w;
    for (int i = 0; i < 50; i++) begin
      if (in_ready_a[d]) begin
        s = cyc + 1;
        break;
      end
      @(posedge clk); #1;
    end
    sbq[d].push_back(mk(w, seq, p, s));
    @(posedge clk); #1;
    if (!hold) begin
      in_valid_a[d] = 1'b0;
      in_data_a[d]  = ~w;   // later changes must not affect the frame
    end
  endtask

  task automatic wait_until(input int c);
    for (int i = 0; i < 40; i++) begin
      if (cyc >= c) break;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int s;
    for (int d = 0; d < N_DUT; d++) begin
      rst_a[d] = 1'b1; in_valid_a[d] = 1'b0; in_data_a[d] = 4'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < N_DUT; d++) rst_a[d] = 1'b0;
    started = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // LSB first 1011 -> 1,1,0,1 ; MSB first 1011 -> 1,0,1,1 ; parity 1
    send(0, 4'b1011, 4'b1101, 1'b1, 1'b0, s);
    send(1, 4'b1011, 4'b1011, 1'b1, 1'b0, s);
    // gap instance: F -> 1,1,1,1, parity 0, then 3 idle cycles
    send(2, 4'hF, 4'b1111, 1'b0, 1'b0, s);

    // held valid: 3 then C, second frame starts one cycle after the first ends
    send(0, 4'h3, 4'b1100, 1'b0, 1'b1, s);
    in_data_a[0] = 4'hC;
    sbq[0].push_back(mk(4'hC, 4'b0011, 1'b0, s + FL + 1));
    wait_until(s + FL + 1);
    in_valid_a[0] = 1'b0;

    // held valid on the gap instance: 8 then 1 (parity 1 each)
    send(2, 4'b1000, 4'b0001, 1'b1, 1'b1, s);
    in_data_a[2] = 4'b0001;
    sbq[2].push_back(mk(4'b0001, 4'b1000, 1'b1, s + FL + 1 + GAP2));
    wait_until(s + FL + 1 + GAP2);
    in_valid_a[2] = 1'b0;

    // reset during the second strobe of A, then 5 -> 1,0,1,0
    send(0, 4'hA, 4'b0101, 1'b0, 1'b0, s);
    @(posedge clk); #1;
    rst_a[0] = 1'b1;
    @(posedge clk); #1;
    rst_a[0] = 1'b0;
    @(posedge clk); #1;
    send(0, 4'h5, 4'b1010, 1'b0, 1'b0, s);

    // 0111 LSB first -> 1,1,1,0, parity 1
    send(0, 4'b0111, 4'b1110, 1'b1, 1'b0, s);

    // a word offered while busy must be dropped, not queued
    send(0, 4'h6, 4'b0110, 1'b0, 1'b0, s);
    in_valid_a[0] = 1'b1;
    in_data_a[0]  = 4'h9;
    @(posedge clk); #1;
    in_valid_a[0] = 1'b0;

    // MSB first 0111 -> 0,1,1,1 parity 1 ; 0110 -> 0,1,1,0 parity 0
    send(1, 4'b0111, 4'b0111, 1'b1, 1'b0, s);
    send(1, 4'h6, 4'b0110, 1'b0, 1'b0, s);

    // reset during the gap of the gap instance
    send(2, 4'h5, 4'b1010, 1'b0, 1'b0, s);
    repeat (FL) @(posedge clk);
    #1;
    rst_a[2] = 1'b1;
    @(posedge clk); #1;
    rst_a[2] = 1'b0;
    send(2, 4'h3, 4'b1100, 1'b0, 1'b0, s);

    repeat (20) @(posedge clk);
    #1;
    done = 1'b1;
    repeat (5) @(posedge clk);
  end

endmodule
